// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions: per-axis timing bundle, standard
// mode constant sets, axis segment encoding and counter width helpers.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int front;
    int sync;
    int back;
    int pol;
  } axis_timing_t;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } segment_e;

  localparam axis_timing_t SVGA_800x600_40M_H = '{
    active: 800, front: 40, sync: 128, back: 88, pol: 1
  };
  localparam axis_timing_t SVGA_800x600_40M_V = '{
    active: 600, front: 1, sync: 4, back: 23, pol: 1
  };

  localparam axis_timing_t VGA_640x480_25M_H = '{
    active: 640, front: 16, sync: 96, back: 48, pol: 0
  };
  localparam axis_timing_t VGA_640x480_25M_V = '{
    active: 480, front: 10, sync: 2, back: 33, pol: 0
  };

  function automatic int axis_total(input axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

  // Bits needed to hold 0..total-1.
  function automatic int min_cw(input int total);
    if (total <= 2) return 1;
    return $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap chaining plus segment decode.
// Ports: clk, reset, en, wrap_in -> pos, wrap_out, blank, sync_region.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FRONT  = 40,
  parameter int SYNC   = 128,
  parameter int BACK   = 88,
  parameter int CW     = 12,
  parameter int START  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          wrap_in,
  output logic [CW-1:0] pos,
  output logic          wrap_out,
  output logic          blank,
  output logic          sync_region
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] HOME      = CW'(START);
  localparam logic [CW-1:0] ACT_END   = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FRONT);
  // Inclusive upper bound so a sync ending at TOTAL cannot overflow CW.
  localparam logic [CW-1:0] SYNC_LAST = CW'(ACTIVE + FRONT + SYNC - 1);

  segment_e seg;
  logic     at_last;

  if (START < 0 || START >= TOTAL) begin : g_err_start
    $error("vga_axis_counter: START outside 0..TOTAL-1");
  end

  assign at_last  = (pos == LAST);
  assign wrap_out = wrap_in & at_last;

  // wrap_in doubles as the step request: the lower axis steps on every
  // enabled edge, the upper axis only when the lower one wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= HOME;
    end else if (en & wrap_in) begin
      pos <= at_last ? '0 : pos + CW'(1);
    end
  end

  always_comb begin
    seg = SEG_BACK;
    if (pos < ACT_END) begin
      seg = SEG_ACTIVE;
    end else if (pos < SYNC_FIRST) begin
      seg = SEG_FRONT;
    end else if (pos <= SYNC_LAST) begin
      seg = SEG_SYNC;
    end
  end

  assign blank       = (seg != SEG_ACTIVE);
  assign sync_region = (seg == SEG_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with data enable, strobes and a
// look-ahead fetch coordinate running FETCH_LEAD pixels ahead of display.
// Ports: clk_pixel, reset, enable -> hsync, vsync, hblank, vblank, de,
//        x, y, line_start, frame_start, fetch_valid, fetch_x, fetch_y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = SVGA_800x600_40M_H.active,
  parameter int H_FRONT    = SVGA_800x600_40M_H.front,
  parameter int H_SYNC     = SVGA_800x600_40M_H.sync,
  parameter int H_BACK     = SVGA_800x600_40M_H.back,
  parameter int V_ACTIVE   = SVGA_800x600_40M_V.active,
  parameter int V_FRONT    = SVGA_800x600_40M_V.front,
  parameter int V_SYNC     = SVGA_800x600_40M_V.sync,
  parameter int V_BACK     = SVGA_800x600_40M_V.back,
  parameter int H_SYNC_POL = SVGA_800x600_40M_H.pol,
  parameter int V_SYNC_POL = SVGA_800x600_40M_V.pol,
  parameter int CW         = 12,
  parameter int FETCH_LEAD = 2
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;

  localparam logic HS_ON  = (H_SYNC_POL != 0);
  localparam logic VS_ON  = (V_SYNC_POL != 0);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_OFF = ~VS_ON;

  if (H_SYNC < 1 || V_SYNC < 1) begin : g_err_sync
    $error("vga_timing_gen: sync pulse widths must be nonzero");
  end
  if (CW < min_cw(H_TOTAL) || CW < min_cw(V_TOTAL)) begin : g_err_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (FETCH_LEAD < 0 || FETCH_LEAD > H_BLANK) begin : g_err_lead
    $error("vga_timing_gen: FETCH_LEAD outside 0..H_BLANK");
  end

  logic [CW-1:0] col;
  logic [CW-1:0] line;
  logic [CW-1:0] fcol;
  logic [CW-1:0] fline;
  logic          col_wrap;
  logic          fcol_wrap;
  logic          line_wrap;
  logic          fline_wrap;
  logic          col_blank;
  logic          line_blank;
  logic          fcol_blank;
  logic          fline_blank;
  logic          col_sync;
  logic          line_sync;
  logic          fcol_sync;
  logic          fline_sync;

  // Display position.
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .CW     (CW),
    .START  (0)
  ) u_col (
    .clk         (clk_pixel),
    .reset       (reset),
    .en          (enable),
    .wrap_in     (1'b1),
    .pos         (col),
    .wrap_out    (col_wrap),
    .blank       (col_blank),
    .sync_region (col_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .CW     (CW),
    .START  (0)
  ) u_line (
    .clk         (clk_pixel),
    .reset       (reset),
    .en          (enable),
    .wrap_in     (col_wrap),
    .pos         (line),
    .wrap_out    (line_wrap),
    .blank       (line_blank),
    .sync_region (line_sync)
  );

  // Fetch position: same raster, preset FETCH_LEAD pixels ahead. The lead
  // never exceeds the horizontal blanking, so the preset stays on line 0.
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .CW     (CW),
    .START  (FETCH_LEAD)
  ) u_fcol (
    .clk         (clk_pixel),
    .reset       (reset),
    .en          (enable),
    .wrap_in     (1'b1),
    .pos         (fcol),
    .wrap_out    (fcol_wrap),
    .blank       (fcol_blank),
    .sync_region (fcol_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .CW     (CW),
    .START  (0)
  ) u_fline (
    .clk         (clk_pixel),
    .reset       (reset),
    .en          (enable),
    .wrap_in     (fcol_wrap),
    .pos         (fline),
    .wrap_out    (fline_wrap),
    .blank       (fline_blank),
    .sync_region (fline_sync)
  );

  logic unused_flags;
  assign unused_flags = &{1'b0, line_wrap, fline_wrap,
                          fcol_sync, fline_sync};

  // Outputs register the counter value of this edge while the counters
  // step past it, so every output lags the counter by one enabled edge.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hsync       <= HS_OFF;
      vsync       <= VS_OFF;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else if (enable) begin
      hsync       <= col_sync ? HS_ON : HS_OFF;
      vsync       <= line_sync ? VS_ON : VS_OFF;
      hblank      <= col_blank;
      vblank      <= line_blank;
      de          <= ~col_blank & ~line_blank;
      x           <= col;
      y           <= line;
      line_start  <= (col == '0);
      frame_start <= (col == '0) & (line == '0);
      fetch_valid <= ~fcol_blank & ~fline_blank;
      fetch_x     <= fcol;
      fetch_y     <= fline;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: five generator instances (default SVGA, VGA, and
// a small raster at three fetch leads) against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int CW = 12;
  localparam int NI = 5;

  localparam int HA[NI] = '{800, 640, 16, 16, 16};
  localparam int HF[NI] = '{40, 16, 4, 4, 4};
  localparam int HS[NI] = '{128, 96, 6, 6, 6};
  localparam int HB[NI] = '{88, 48, 6, 6, 6};
  localparam int VA[NI] = '{600, 480, 10, 10, 10};
  localparam int VF[NI] = '{1, 10, 2, 2, 2};
  localparam int VS[NI] = '{4, 2, 3, 3, 3};
  localparam int VB[NI] = '{23, 33, 5, 5, 5};
  localparam int HP[NI] = '{1, 0, 0, 0, 0};
  localparam int VP[NI] = '{1, 0, 1, 1, 1};
  localparam int FL[NI] = '{2, 2, 0, 2, 16};

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          hb;
    logic          vb;
    logic          de;
    logic          ls;
    logic          fs;
    logic          fv;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] fx;
    logic [CW-1:0] fy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  obs_t obs [NI];

  int n      = 0;
  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic          hs, vs, hb, vb, de, ls, fs, fv;
    logic [CW-1:0] x, y, fx, fy;
    if (g == 0) begin : g_def
      vga_timing_gen u_dut (
        .clk_pixel (clk), .reset (rst), .enable (en),
        .hsync (hs), .vsync (vs), .hblank (hb), .vblank (vb),
        .de (de), .x (x), .y (y),
        .line_start (ls), .frame_start (fs),
        .fetch_valid (fv), .fetch_x (fx), .fetch_y (fy)
      );
    end else begin : g_par
      vga_timing_gen #(
        .H_ACTIVE (HA[g]), .H_FRONT (HF[g]),
        .H_SYNC (HS[g]), .H_BACK (HB[g]),
        .V_ACTIVE (VA[g]), .V_FRONT (VF[g]),
        .V_SYNC (VS[g]), .V_BACK (VB[g]),
        .H_SYNC_POL (HP[g]), .V_SYNC_POL (VP[g]),
        .CW (CW), .FETCH_LEAD (FL[g])
      ) u_dut (
        .clk_pixel (clk), .reset (rst), .enable (en),
        .hsync (hs), .vsync (vs), .hblank (hb), .vblank (vb),
        .de (de), .x (x), .y (y),
        .line_start (ls), .frame_start (fs),
        .fetch_valid (fv), .fetch_x (fx), .fetch_y (fy)
      );
    end
    assign obs[g] = {hs, vs, hb, vb, de, ls, fs, fv, x, y, fx, fy};
  end

  // Expected outputs after k enabled, non-reset edges since reset:
  // the raster is a linear pixel index wrapped by the frame size.
  function automatic obs_t model(input int i, input int k);
    obs_t o;
    int ht, vt, fr, p, q, xx, yy, fx, fy;
    logic in_h, in_v;
    o  = '0;
    ht = HA[i] + HF[i] + HS[i] + HB[i];
    vt = VA[i] + VF[i] + VS[i] + VB[i];
    fr = ht * vt;
    if (k == 0) begin
      o.hb = 1'b1;
      o.vb = 1'b1;
      o.hs = (HP[i] == 0);
      o.vs = (VP[i] == 0);
      return o;
    end
    p  = (k - 1) % fr;
    xx = p % ht;
    yy = p / ht;
    in_h = (xx >= HA[i] + HF[i]) && (xx < HA[i] + HF[i] + HS[i]);
    in_v = (yy >= VA[i] + VF[i]) && (yy < VA[i] + VF[i] + VS[i]);
    o.x  = CW'(xx);
    o.y  = CW'(yy);
    o.hb = (xx >= HA[i]);
    o.vb = (yy >= VA[i]);
    o.de = (xx < HA[i]) && (yy < VA[i]);
    o.hs = (in_h == (HP[i] != 0));
    o.vs = (in_v == (VP[i] != 0));
    o.ls = (xx == 0);
    o.fs = (p == 0);
    q  = (p + FL[i]) % fr;
    fx = q % ht;
    fy = q / ht;
    o.fx = CW'(fx);
    o.fy = CW'(fy);
    o.fv = (fx < HA[i]) && (fy < VA[i]);
    return o;
  endfunction

  function automatic string tag_of(input int i);
    case (i)
      0:       return "svga";
      1:       return "vga";
      2:       return "small_fl0";
      3:       return "small_fl2";
      default: return "small_fl16";
    endcase
  endfunction

  task automatic chk_o(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
  endtask

  task automatic chk_v(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) n = 0;
    else if (e) n++;
    #1;
    for (int i = 0; i < NI; i++) chk_o(tag_of(i), obs[i], model(i, n));
  endtask

  int hs_hi, first_h, vga_lo, first_v;
  obs_t m;

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_v("rst_de", int'(obs[0].de), 0);
    chk_v("rst_vga_hs", int'(obs[1].hs), 1);

    step(1'b0, 1'b1);
    chk_v("first_x", int'(obs[0].x), 0);
    chk_v("first_de", int'(obs[0].de), 1);
    chk_v("first_fs", int'(obs[0].fs), 1);
    chk_v("first_fx", int'(obs[0].fx), 2);
    chk_v("fl16_fx", int'(obs[4].fx), 16);
    chk_v("fl16_fv", int'(obs[4].fv), 0);

    hs_hi = 0; first_h = -1; vga_lo = 0; first_v = -1;
    for (int k = 0; k < 1056; k++) begin
      if (k > 0) step(1'b0, 1'b1);
      if (obs[0].hs) begin
        hs_hi++;
        if (first_h < 0) first_h = int'(obs[0].x);
      end
      if (!obs[1].hs) begin
        vga_lo++;
        if (first_v < 0) first_v = int'(obs[1].x);
      end
    end
    chk_v("svga_hs_width", hs_hi, 128);
    chk_v("svga_hs_first", first_h, 840);
    chk_v("vga_hs_width", vga_lo, 96);
    chk_v("vga_hs_first", first_v, 656);

    step(1'b0, 1'b1);
    chk_v("line1_x", int'(obs[0].x), 0);
    chk_v("line1_y", int'(obs[0].y), 1);
    chk_v("line1_ls", int'(obs[0].ls), 1);
    chk_v("line1_fs", int'(obs[0].fs), 0);

    for (int k = 0; k < 1500; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 1500; k++) step(1'b0, (k % 3) == 0);
    for (int k = 0; k < 1500; k++) step(1'b0, 1'($urandom % 2));

    // Reset wins over a low enable.
    step(1'b1, 1'b0);
    chk_v("rst_noen_hb", int'(obs[0].hb), 1);
    step(1'b0, 1'b1);

    // Mid-line reset once the default raster shows x=500.
    m = model(0, n);
    for (int k = 0; k < 1200 && m.x != CW'(500); k++) begin
      step(1'b0, 1'b1);
      m = model(0, n);
    end
    chk_v("reach_x500", int'(obs[0].x), 500);
    step(1'b1, 1'b1);
    chk_v("mid_rst_de", int'(obs[0].de), 0);
    chk_v("mid_rst_hb", int'(obs[0].hb), 1);
    chk_v("mid_rst_vb", int'(obs[0].vb), 1);
    chk_v("mid_rst_hs", int'(obs[0].hs), 0);
    chk_v("mid_rst_vga_vs", int'(obs[1].vs), 1);
    step(1'b0, 1'b1);
    chk_v("restart_x", int'(obs[0].x), 0);
    chk_v("restart_y", int'(obs[0].y), 0);
    chk_v("restart_fs", int'(obs[0].fs), 1);

    for (int k = 0; k < 2000; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 700) == 0, ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed SVGA sync block.
- Every timing value is a parameter. Adds synchronous reset, pixel clock enable, and pixel coordinates.
- Adds a data-enable output, line/frame start strobes, and a look-ahead fetch coordinate port, so framebuffer reads can be issued FETCH_LEAD pixels before display.
- Sits between the pixel clock domain and the pixel source / DAC output stage.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BACK, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BACK, 23, vertical back porch (lines)
H_SYNC_POL, 1, 1 = hsync active high
V_SYNC_POL, 1, 1 = vsync active high
CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
FETCH_LEAD, 2, fetch lead in pixels; 0 <= FETCH_LEAD <= H_FRONT+H_SYNC+H_BACK

Ports:
clk_pixel  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  pixel clock enable; counters and all registered outputs advance only when high
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
hblank  out  1  high outside horizontal active region
vblank  out  1  high outside vertical active region
de  out  1  data enable = ~hblank & ~vblank
x  out  CW  current displayed column (0..H_TOTAL-1)
y  out  CW  current displayed line (0..V_TOTAL-1)
line_start  out  1  one-enabled-cycle strobe, x==0
frame_start  out  1  one-enabled-cycle strobe, x==0 & y==0
fetch_valid  out  1  fetch_x/fetch_y name an active pixel
fetch_x  out  CW  column shown FETCH_LEAD enabled cycles later
fetch_y  out  CW  line shown FETCH_LEAD enabled cycles later

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_ params; V_TOTAL = sum of the four V_ params.
- Internal position counter (col, line):
  - col increments mod H_TOTAL on each enabled edge.
  - line increments mod V_TOTAL when col wraps.
  - line wraps to 0 after V_TOTAL-1 at the same edge col wraps.
- Outputs are registered, one enabled edge of latency from the counter. After edge k, outputs describe counter position k.
- Reset behaviour, at any time including mid-frame:
  - Counter goes to (0,0).
  - Outputs: de=0, hblank=1, vblank=1, hsync/vsync at inactive level, x=y=0, line_start=frame_start=0, fetch_valid=0, fetch_x=fetch_y=0.
  - The first enabled edge with reset low presents position (0,0): de=1, line_start=1, frame_start=1.
  - That same edge presents fetch for position (FETCH_LEAD,0) as if the raster had already been running.
- Reset has priority over enable.
- enable low: counter and every output hold their values. Strobes also hold, so consumers must qualify them with enable.
- Horizontal regions by col:
  - active [0, H_ACTIVE)
  - hsync asserted [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC)
- Vertical regions by line:
  - active [0, V_ACTIVE)
  - vsync asserted [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC)
  - vsync and vblank change only at x==0.
- Fetch position = counter position advanced by FETCH_LEAD pixels, with the same wrap rules.
  - Line increments when the advanced column wraps; frame wraps V_TOTAL-1 -> 0.
  - fetch_valid = fetch position is in the active region.
  - Invariant: if fetch_valid=1 with (fx,fy) at edge k, then de=1 with x=fx, y=fy at edge k+FETCH_LEAD (enable high throughout).
- FETCH_LEAD=0: fetch outputs equal x/y, and fetch_valid equals de.
- All arithmetic is unsigned CW-bit; there is no overflow given the CW constraint.
- Elaboration check: H_SYNC>0, V_SYNC>0, the CW range holds, and FETCH_LEAD is within its range.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constant sets: SVGA_800x600_40M (defaults) and VGA_640x480_25M (640/16/96/48, 480/10/2/33, both polarities 0);
  - a function computing minimum CW.
- Sub-module vga_axis_counter, instantiated once per axis:
  - inputs: count enable, wrap-in;
  - parameters: ACTIVE/FRONT/SYNC/BACK;
  - outputs: position, wrap-out, blank, sync-region flags.
- The fetch path is a second pair of axis counters preset to the FETCH_LEAD offset at reset.

Test Plan:
1. Reset, then release with enable=1 (defaults): first edge gives x=0, y=0, de=1, frame_start=1, fetch_x=2. After 1056 edges: x=0, y=1, line_start=1, frame_start=0.
2. Horizontal timing: hblank rises at x=800; hsync is high for x=840..967 (128 cycles); hsync is low again at x=968; line length is 1056 edges.
3. Vertical timing, full frame: vblank at y=600..627; vsync high for y=601..604, transitions only at x==0; frame_start period is 1056*628=663168 edges.
4. Fetch invariant: at x=1054, y=599, fetch=(0,600), fetch_valid=0. At x=1054, y=627, fetch=(0,0), fetch_valid=1, and de at (0,0) follows 2 edges later. Check the invariant exhaustively over a frame with FETCH_LEAD = 0, 2 and 64.
5. Enable gating: enable toggling 1-of-3 holds all outputs on disabled edges; sequence equals the ungated run; frame length is 3x in clk_pixel edges.
6. Mid-frame reset at x=500, y=300: the next edge gives de=0, hblank=vblank=1, syncs inactive. On release, position restarts at (0,0). Repeat with VGA_640x480_25M constants and polarity 0: hsync low for x=656..751.
